// File: rtl/counter_pkg.sv
// Shared BCD types and helpers for the BCD counter family.
package counter_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned BCD_MAX = 9;
    localparam int unsigned BIN_W   = 7;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
        return digit <= BCD_W'(BCD_MAX);
    endfunction

    // Binary value of a two-digit BCD pair; only meaningful when both digits are valid.
    function automatic logic [BIN_W-1:0] bcd2bin2(input logic [BCD_W-1:0] tens,
                                                  input logic [BCD_W-1:0] ones);
        return BIN_W'(tens) * BIN_W'(10) + BIN_W'(ones);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIV_N enable prescaler; TICK marks the last enabled clock of each period.
module tick_prescaler #(
    parameter int unsigned DIV_N = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam int unsigned    CNT_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_N - 1);

    logic [CNT_W-1:0] cnt;

    // With DIV_N == 1, LAST is 0 and the counter never leaves 0.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (CLR) begin
            cnt <= '0;
        end else if (EN) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign TICK = EN & RST_N & (cnt == LAST);

endmodule

// File: rtl/bcd_mod_up_counter.sv
// Two-digit BCD up-counter, modulus MOD, with prescaled enable and registered carry-out.
module bcd_mod_up_counter
    import counter_pkg::*;
#(
    parameter int unsigned MOD   = 60,
    parameter int unsigned DIV_N = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             CLR,
    input  logic             LD,
    input  logic [7:0]       LD_VAL,
    output logic [BCD_W-1:0] CNT_ONES,
    output logic [BCD_W-1:0] CNT_TENS,
    output logic             TICK,
    output logic             TC,
    output logic             CO
);

    localparam logic [BIN_W-1:0] MOD_V  = BIN_W'(MOD);
    localparam logic [BIN_W-1:0] LAST_V = BIN_W'(MOD - 1);

    bcd2_t            cur;
    bcd2_t            nxt;
    bcd2_t            ld_bcd;
    logic             co_nxt;
    logic             tick;
    logic [BIN_W-1:0] cur_bin;
    logic [BIN_W-1:0] ld_bin;
    logic             cur_legal;
    logic             ld_legal;
    logic             cur_last;

    tick_prescaler #(
        .DIV_N (DIV_N)
    ) u_presc (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (CLR | LD),
        .EN    (EN),
        .TICK  (tick)
    );

    assign ld_bcd    = bcd2_t'(LD_VAL);
    assign cur_bin   = bcd2bin2(cur.tens, cur.ones);
    assign ld_bin    = bcd2bin2(ld_bcd.tens, ld_bcd.ones);
    assign cur_legal = bcd_valid(cur.tens) & bcd_valid(cur.ones) & (cur_bin < MOD_V);
    assign ld_legal  = bcd_valid(ld_bcd.tens) & bcd_valid(ld_bcd.ones) & (ld_bin < MOD_V);
    assign cur_last  = cur_legal & (cur_bin == LAST_V);

    // Next value: clear > load > counted step > hold; illegal values fall back to 00.
    always_comb begin
        nxt    = cur;
        co_nxt = 1'b0;
        if (CLR) begin
            nxt = '0;
        end else if (LD) begin
            nxt = ld_legal ? ld_bcd : '0;
        end else if (tick) begin
            if (!cur_legal) begin
                nxt = '0;
            end else if (cur_last) begin
                nxt    = '0;
                co_nxt = 1'b1;
            end else if (cur.ones == BCD_W'(BCD_MAX)) begin
                nxt.ones = '0;
                nxt.tens = cur.tens + BCD_W'(1);
            end else begin
                nxt.ones = cur.ones + BCD_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cur <= '0;
            CO  <= 1'b0;
        end else begin
            cur <= nxt;
            CO  <= co_nxt;
        end
    end

    assign CNT_TENS = cur.tens;
    assign CNT_ONES = cur.ones;
    assign TICK     = tick;
    assign TC       = cur_last;

endmodule

// File: tb/tb_bcd_mod_up_counter.sv
// Self-checking bench: MOD=60 main unit, DIV_N=4 unit, and a MOD=100 cascade pair.
module tb_bcd_mod_up_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en_m, clr_m, ld_m;
    logic [7:0] ldv_m;
    logic [3:0] ones_m, tens_m;
    logic       tick_m, tc_m, co_m;

    logic       en_d;
    logic       zero = 1'b0;
    logic [7:0] zero8 = 8'h00;
    logic [3:0] ones_d, tens_d;
    logic       tick_d, tc_d, co_d;

    logic       en_l;
    logic [3:0] ones_l, tens_l, ones_h, tens_h;
    logic       tick_l, tc_l, co_l, tick_h, tc_h, co_h;

    bcd_mod_up_counter #(.MOD(60), .DIV_N(1)) u_m (
        .CLK(clk), .RST_N(rst_n), .EN(en_m), .CLR(clr_m), .LD(ld_m), .LD_VAL(ldv_m),
        .CNT_ONES(ones_m), .CNT_TENS(tens_m), .TICK(tick_m), .TC(tc_m), .CO(co_m));

    bcd_mod_up_counter #(.MOD(60), .DIV_N(4)) u_d (
        .CLK(clk), .RST_N(rst_n), .EN(en_d), .CLR(zero), .LD(zero), .LD_VAL(zero8),
        .CNT_ONES(ones_d), .CNT_TENS(tens_d), .TICK(tick_d), .TC(tc_d), .CO(co_d));

    bcd_mod_up_counter #(.MOD(100), .DIV_N(1)) u_lo (
        .CLK(clk), .RST_N(rst_n), .EN(en_l), .CLR(zero), .LD(zero), .LD_VAL(zero8),
        .CNT_ONES(ones_l), .CNT_TENS(tens_l), .TICK(tick_l), .TC(tc_l), .CO(co_l));

    bcd_mod_up_counter #(.MOD(100), .DIV_N(1)) u_hi (
        .CLK(clk), .RST_N(rst_n), .EN(co_l), .CLR(zero), .LD(zero), .LD_VAL(zero8),
        .CNT_ONES(ones_h), .CNT_TENS(tens_h), .TICK(tick_h), .TC(tc_h), .CO(co_h));

    typedef struct {
        logic       rst_n, en, clr, ld;
        logic [7:0] ld_val;
        int         tens, ones;
        logic       co, tc;
        string      name;
    } vec_t;

    typedef struct {
        int    tens, ones;
        logic  co, tc;
        string name;
    } exp_t;

    exp_t sb[$];
    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of main-unit stimulus, queue its expectation, compare after the edge.
    task automatic drive_m(input logic r, input logic e, input logic c, input logic l,
                           input logic [7:0] v, input int et, input int eo,
                           input logic eco, input logic etc, input string name);
        exp_t x;
        exp_t got;
        rst_n = r; en_m = e; clr_m = c; ld_m = l; ldv_m = v;
        x.tens = et; x.ones = eo; x.co = eco; x.tc = etc; x.name = name;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.name, ".tens"}, int'(tens_m), got.tens);
        chk({got.name, ".ones"}, int'(ones_m), got.ones);
        chk({got.name, ".co"},   int'(co_m),   int'(got.co));
        chk({got.name, ".tc"},   int'(tc_m),   int'(got.tc));
    endtask

    initial begin
        int p;
        int v;
        rst_n = 1'b0; en_m = 1'b0; clr_m = 1'b0; ld_m = 1'b0; ldv_m = 8'h00;
        en_d = 1'b0; en_l = 1'b0;

        // Reset state, then full 00..59 sweep and wrap.
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, "reset");
        for (int i = 1; i <= 61; i++) begin
            rst_n = 1'b1; en_m = 1'b1;
            #1;
            chk("sweep.tick", int'(tick_m), 1);
            drive_m(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, (i % 60) / 10, (i % 60) % 10,
                    i == 60, (i % 60) == 59, $sformatf("sweep%0d", i));
        end

        // Mid-count reset and a reset glitch between edges.
        drive_m(1'b1, 1'b0, 1'b0, 1'b1, 8'h37, 3, 7, 1'b0, 1'b0, "ld37");
        rst_n = 1'b0; en_m = 1'b1;
        #1;
        chk("rst.tick", int'(tick_m), 0);
        drive_m(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, "rst_mid");
        drive_m(1'b1, 1'b0, 1'b0, 1'b1, 8'h37, 3, 7, 1'b0, 1'b0, "ld37b");
        en_m = 1'b1; rst_n = 1'b0;
        #2;
        chk("glitch.tick", int'(tick_m), 0);
        rst_n = 1'b1;
        #1;
        drive_m(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3, 8, 1'b0, 1'b0, "glitch");

        // Load and control-priority vectors.
        vq.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b1, 8'h58, 5, 8, 1'b0, 1'b0, "ld58"});
        vq.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5, 9, 1'b0, 1'b1, "inc59"});
        vq.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 1'b1, 1'b0, "wrap00"});
        vq.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1, 1'b0, 1'b0, "post01"});
        vq.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 8'h7A, 0, 0, 1'b0, 1'b0, "ld7A"});
        vq.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 8'h42, 4, 2, 1'b0, 1'b0, "ld42"});
        vq.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 8'h60, 0, 0, 1'b0, 1'b0, "ld60"});
        vq.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 8'h59, 5, 9, 1'b0, 1'b1, "ld59"});
        vq.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b1, 8'h45, 4, 5, 1'b0, 1'b0, "ld_at59"});
        vq.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b1, 8'h25, 0, 0, 1'b0, 1'b0, "clr_ld"});
        vq.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 8'h14, 1, 4, 1'b0, 1'b0, "ld14"});
        vq.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 3, 3, 1'b0, 1'b0, "ld_en14"});
        for (int i = 0; i < 5; i++)
            vq.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3, 3, 1'b0, 1'b0, "hold"});
        vq.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 8'h9A, 0, 0, 1'b0, 1'b0, "ld9A"});
        vq.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 8'h42, 4, 2, 1'b0, 1'b0, "ld42b"});
        vq.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 0, 0, 1'b0, 1'b0, "ldA0"});
        vq.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 8'h09, 0, 9, 1'b0, 1'b0, "ld09"});
        vq.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1, 0, 1'b0, 1'b0, "ones_wrap"});
        vq.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, "clr"});
        foreach (vq[i])
            drive_m(vq[i].rst_n, vq[i].en, vq[i].clr, vq[i].ld, vq[i].ld_val,
                    vq[i].tens, vq[i].ones, vq[i].co, vq[i].tc, vq[i].name);
        en_m = 1'b0;

        // DIV_N=4: tick on every 4th enabled clock, phase kept across an EN=0 gap.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("div.reset", int'(tens_d) * 10 + int'(ones_d), 0);
        chk("div.reset_co", int'(co_d), 0);
        p = 0;
        v = 0;
        for (int i = 0; i < 20; i++) begin
            en_d = !(i >= 9 && i < 12);
            #1;
            chk($sformatf("div.tick%0d", i), int'(tick_d), int'(en_d && p == 3));
            @(posedge clk);
            #1;
            if (en_d) begin
                if (p == 3) begin
                    v++;
                    p = 0;
                end else begin
                    p++;
                end
            end
            chk($sformatf("div.val%0d", i), int'(tens_d) * 10 + int'(ones_d), v);
        end
        en_d = 1'b0;

        // Cascaded modulo-100 pair: upper steps once per lower wrap.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en_l = 1'b1;
        for (int k = 1; k <= 205; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lo.val%0d", k), int'(tens_l) * 10 + int'(ones_l), k % 100);
            chk($sformatf("lo.co%0d", k), int'(co_l), int'((k % 100) == 0));
            chk($sformatf("hi.val%0d", k), int'(tens_h) * 10 + int'(ones_h), (k - 1) / 100);
            if ((k % 100) == 99)
                chk($sformatf("lo.tc%0d", k), int'(tc_l), 1);
        end
        en_l = 1'b0;

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
